truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//  Sweeps an N_IN-bit input vector over all 2^N_IN codes and drives it into two combinational units under comparison.
//  Unit A is a structural implementation; unit B is its equation form. Samples y_a and y_b, then counts mismatches.
//  Captures the first failing vector and reports pass/fail through a start/busy/done handshake.
//  Sits at lab top level, between the switches/buttons and the gate-level exercise modules.
// PARAMETERS
//  N_IN    4   width of the stimulus vector (legal range 2..8)
//  SETTLE  1   cycles vec is held before sampling (minimum 1)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  start           in   1       one-cycle pulse; begins a sweep
//  abort           in   1       one-cycle pulse; cancels a sweep
//  y_a             in   1       output of unit A
//  y_b             in   1       output of unit B
//  vec             out  N_IN    stimulus {a,b,c,d...}, MSB = a
//  busy            out  1       sweep in progress
//  done            out  1       sweep finished; sticky until next start
//  pass            out  1       done && err_count==0
//  err_count       out  N_IN+1  mismatch count; holds 2^N_IN without overflow
//  first_err_vec   out  N_IN    vec at first mismatch
//  first_err_valid out  1       first_err_vec holds a captured vector
// BEHAVIOUR
//  Reset (rst_n=0): all outputs 0, state IDLE, settle counter 0.
//  All outputs are registered.
//  States:
//   IDLE   -> DRIVE on start; clear err_count, first_err_*, done; vec=0.
//   DRIVE  -> hold vec for SETTLE cycles, then SAMPLE.
//   SAMPLE -> compare. If y_a!=y_b: err_count++. If also !first_err_valid: first_err_vec=vec, first_err_valid=1.
//             If vec==all-ones, go to DONE. Else vec++ and return to DRIVE.
//   DONE   -> done=1, busy=0, vec=0. On start, same action as from IDLE.
//  busy=1 in DRIVE and SAMPLE only.
//  Timing: each vector costs SETTLE+1 cycles. With start accepted at edge t, done rises at edge t+2^N_IN*(SETTLE+1)+1.
//  vec never wraps inside a sweep; the all-ones code is sampled exactly once.
//  start while busy: ignored, with no restart and no counter change.
//  abort while busy: next state IDLE; vec=0, busy=0, done=0.
//   err_count and first_err_* keep partial values until the next start.
//  abort in IDLE/DONE: ignored.
//  start and abort in the same cycle: abort wins when busy; start wins otherwise.
//  rst_n asserted mid-sweep: immediate return to reset values, with no done pulse.
//  y_a/y_b are sampled only in SAMPLE and ignored in every other state.
// STRUCTURE
//  Shared package lab_seq_pkg:
//   state encoding (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3)
//   localparam SETTLE_W = $clog2(SETTLE+1)
//  Sub-module settle_timer: load/count-down counter of width SETTLE_W.
//   Outputs expired when it reaches 0; reloaded on each DRIVE entry.
//  Top level: FSM, vec counter, err_count accumulator, first-error capture.
// TESTING (N_IN=4, SETTLE=1 unless noted)
//  1. y_b tied to y_a from the same function of vec -> done at start+33 cycles, err_count=0, pass=1, first_err_valid=0.
//  2. y_b = y_a ^ (vec==5 || vec==12) -> err_count=2, first_err_vec=4'd5, first_err_valid=1, pass=0.
//  3. y_b = ~y_a for all vec -> err_count=5'd16 (no overflow), first_err_vec=0.
//  4. abort when vec=7 -> next cycle busy=0, vec=0, done=0.
//     A new start then completes normally with err_count reset to 0.
//  5. start pulsed at vec=3 mid-sweep -> ignored; done still at start+33.
//     Then start in DONE -> done drops next cycle and the sweep reruns.
//  6. rst_n low for 1 cycle at vec=9 -> all outputs 0 immediately and no done.
//     SETTLE=3 rerun -> done at start+65.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and helpers for the truth-table sweep sequencer.
package lab_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned SETTLE_DEFAULT = 1;
  localparam int unsigned SETTLE_W       = $clog2(SETTLE_DEFAULT + 1);

  // Counter width able to hold a settle count of 'settle'.
  function automatic int unsigned settle_width(input int unsigned settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Load/count-down settle counter; expired while the count sits at zero.
module settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps vec over every code, compares two unit outputs and records mismatches.
module truth_table_sequencer
  import lab_seq_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            y_a,
  input  logic            y_b,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int unsigned TW = settle_width(SETTLE);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fev_q, fev_d;
  logic            fevv_q, fevv_d;
  logic            tmr_load, tmr_expired;

  // Reload the settle count on every entry into DRIVE.
  assign tmr_load = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);

  settle_timer #(.W(TW)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TW'(SETTLE - 1)),
    .en       (state_q == ST_DRIVE),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fevv_d  = fevv_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fev_d   = '0;
          fevv_d  = 1'b0;
        end else if (state_q == ST_DONE) begin
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
      end
      ST_DRIVE, ST_SAMPLE: begin
        // Abort takes precedence over the sample taken in this cycle.
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == ST_DRIVE) begin
          if (tmr_expired) state_d = ST_SAMPLE;
        end else begin
          if (y_a != y_b) begin
            err_d = err_q + 1'b1;
            if (!fevv_q) begin
              fev_d  = vec_q;
              fevv_d = 1'b1;
            end
          end
          if (vec_q == '1) begin
            state_d = ST_DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DRIVE;
            vec_d   = vec_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
      fevv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fevv_q  <= fevv_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer (N_IN=4, SETTLE=1 and SETTLE=3).
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       y_a, y_b;
  logic [3:0] vec, first_err_vec;
  logic       busy, done, pass, first_err_valid;
  logic [4:0] err_count;
  int         mode = 0;

  logic       start3 = 1'b0, abort3 = 1'b0;
  logic       y_a3;
  logic [3:0] vec3, first_err_vec3;
  logic       busy3, done3, pass3, first_err_valid3;
  logic [4:0] err_count3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic unit_f(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  always_comb begin
    y_a = unit_f(vec);
    case (mode)
      0:       y_b = y_a;
      1:       y_b = y_a ^ ((vec == 4'd5) || (vec == 4'd12));
      default: y_b = ~y_a;
    endcase
    y_a3 = unit_f(vec3);
  end

  truth_table_sequencer #(.N_IN(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .y_a(y_a), .y_b(y_b), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid)
  );

  truth_table_sequencer #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .y_a(y_a3), .y_b(y_a3), .vec(vec3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err_count3), .first_err_vec(first_err_vec3),
    .first_err_valid(first_err_valid3)
  );

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic wait_vec(input logic [3:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (vec == k) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({vec, busy, done, pass, err_count, first_err_vec, first_err_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vec=%0d busy=%b done=%b pass=%b err=%0d fev=%0d fevv=%b, want all 0",
               vec, busy, done, pass, err_count, first_err_vec, first_err_valid);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clean_sweep();
    int n;
    mode = 0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || vec !== 4'd0) begin
      n_fail++;
      $display("FAIL clean_first: got busy=%b vec=%0d, want busy=1 vec=0", busy, vec);
    end
    wait_done(60, n);
    n_checks++;
    if (n !== 33) begin n_fail++; $display("FAIL clean_latency: got %0d cycles, want 33", n); end
    n_checks++;
    if (err_count !== 5'd0 || pass !== 1'b1 || first_err_valid !== 1'b0 || busy !== 1'b0 || vec !== 4'd0) begin
      n_fail++;
      $display("FAIL clean_result: got err=%0d pass=%b fevv=%b busy=%b vec=%0d, want 0 1 0 0 0",
               err_count, pass, first_err_valid, busy, vec);
    end
  endtask

  task automatic test_two_errors();
    int n;
    mode = 1;
    pulse_start();
    wait_done(60, n);
    n_checks++;
    if (err_count !== 5'd2 || first_err_vec !== 4'd5 || first_err_valid !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL two_errors: got err=%0d fev=%0d fevv=%b pass=%b done=%b, want 2 5 1 0 1",
               err_count, first_err_vec, first_err_valid, pass, done);
    end
  endtask

  task automatic test_all_errors();
    int n;
    mode = 2;
    pulse_start();
    wait_done(60, n);
    n_checks++;
    if (err_count !== 5'd16 || first_err_vec !== 4'd0 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL all_errors: got err=%0d fev=%0d fevv=%b pass=%b, want 16 0 1 0",
               err_count, first_err_vec, first_err_valid, pass);
    end
  endtask

  task automatic test_abort();
    int n;
    bit ok;
    mode = 1;
    pulse_start();
    wait_vec(4'd7, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_reach_vec7: got timeout, want vec=7"); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b vec=%0d done=%b, want 0 0 0", busy, vec, done);
    end
    n_checks++;
    if (err_count !== 5'd1 || first_err_vec !== 4'd5 || first_err_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_partial: got err=%0d fev=%0d fevv=%b, want 1 5 1", err_count, first_err_vec, first_err_valid);
    end
    mode = 0;
    pulse_start();
    n_checks++;
    if (err_count !== 5'd0 || first_err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart_clear: got err=%0d fevv=%b, want 0 0", err_count, first_err_valid);
    end
    wait_done(60, n);
    n_checks++;
    if (n !== 33 || err_count !== 5'd0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rerun: got cycles=%0d err=%0d pass=%b, want 33 0 1", n, err_count, pass);
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  pulsed;
    mode = 0;
    pulse_start();
    n = 0;
    pulsed = 1'b0;
    while (!done && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (start) start = 1'b0;
      if (vec == 4'd3 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
    end
    n_checks++;
    if (n !== 33 || err_count !== 5'd0) begin
      n_fail++;
      $display("FAIL start_ignored: got cycles=%0d err=%0d, want 33 0", n, err_count);
    end
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || vec !== 4'd0) begin
      n_fail++;
      $display("FAIL start_in_done: got done=%b busy=%b vec=%0d, want 0 1 0", done, busy, vec);
    end
    wait_done(60, n);
    n_checks++;
    if (n !== 33 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_latency: got cycles=%0d pass=%b, want 33 1", n, pass);
    end
  endtask

  task automatic test_mid_reset();
    int  n;
    bit  ok;
    bit  saw_done;
    mode = 0;
    pulse_start();
    wait_vec(4'd9, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_reach_vec9: got timeout, want vec=9"); end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({vec, busy, done, pass, err_count, first_err_vec, first_err_valid} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got vec=%0d busy=%b done=%b err=%0d, want all 0", vec, busy, done, err_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got done/busy activity=1, want 0");
    end
  endtask

  task automatic test_settle3();
    int n;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    n = 0;
    while (!done3 && n < 120) begin
      @(posedge clk);
      n++;
      #1;
    end
    n_checks++;
    if (n !== 65 || err_count3 !== 5'd0 || pass3 !== 1'b1 || first_err_valid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL settle3: got cycles=%0d err=%0d pass=%b fevv=%b, want 65 0 1 0",
               n, err_count3, pass3, first_err_valid3);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_two_errors();
    test_all_errors();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
